// File: rtl/mips_pkg.sv
// Shared MIPS encoder definitions: branch offset range limits, PC step and result struct.
package mips_pkg;

    localparam logic signed [17:0] OFF_MIN = -18'sd131072;
    localparam logic signed [17:0] OFF_MAX = 18'sd131071;
    localparam logic [31:0]        PC_STEP = 32'd4;

    typedef struct packed {
        logic [15:0] imm16;
        logic        ovf;
        logic        misalign;
    } offset_result_t;

endpackage

// File: rtl/offset_range_check.sv
// Combinational check of a 33-bit byte offset: encodes the 16-bit word immediate and flags
// offsets that are misaligned or fall outside the signed 18-bit branch range.
module offset_range_check
    import mips_pkg::*;
(
    input  logic [32:0]    diff,
    output offset_result_t result
);

    logic signed [32:0] diff_s;
    logic signed [32:0] off_min_s;
    logic signed [32:0] off_max_s;

    always_comb begin
        diff_s          = $signed(diff);
        off_min_s       = $signed({{15{OFF_MIN[17]}}, OFF_MIN});
        off_max_s       = $signed({{15{OFF_MAX[17]}}, OFF_MAX});
        // Immediate is the truncated field even when a flag is raised.
        result.imm16    = diff[17:2];
        result.ovf      = (diff_s < off_min_s) || (diff_s > off_max_s);
        result.misalign = |diff[1:0];
    end

endmodule

// File: rtl/branch_offset_narrow.sv
// Two-stage branch-offset encoder with valid/ready handshakes on both sides.
// Optional error counter built when BRANCH_OFFSET_NARROW_ERRCNT_EN is defined.
module branch_offset_narrow
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm16,
    output logic        out_ovf,
    output logic        out_misalign,
    output logic [7:0]  err_cnt
);

    logic           s1_valid_q, s1_valid_d;
    logic [32:0]    s1_diff_q, s1_diff_d;
    logic           out_valid_q, out_valid_d;
    offset_result_t out_res_q, out_res_d;
    offset_result_t chk_res;

    logic s2_ready;
    logic accept;
    logic s1_to_s2;

    offset_range_check u_range_check (
        .diff   (s1_diff_q),
        .result (chk_res)
    );

    always_comb begin
        s2_ready = ~out_valid_q | out_ready;
        in_ready = ~s1_valid_q | s2_ready;
        accept   = in_valid & in_ready;
        s1_to_s2 = s1_valid_q & s2_ready;

        s1_valid_d = accept | (s1_valid_q & ~s2_ready);
        s1_diff_d  = s1_diff_q;
        if (accept) begin
            s1_diff_d = {in_target[31], in_target} - {in_pc[31], in_pc} - {1'b0, PC_STEP};
        end

        // A consume and a new transfer in the same cycle keep out_valid high.
        out_valid_d = s1_to_s2 | (out_valid_q & ~out_ready);
        out_res_d   = s1_to_s2 ? chk_res : out_res_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_imm16    = out_res_q.imm16;
    assign out_ovf      = out_res_q.ovf;
    assign out_misalign = out_res_q.misalign;

`ifdef BRANCH_OFFSET_NARROW_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_valid_q && out_ready && (out_res_q.ovf || out_res_q.misalign)
            && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_branch_offset_narrow.sv
// Directed self-checking bench for branch_offset_narrow (both configurations of the error counter).
module tb_branch_offset_narrow;

`ifdef BRANCH_OFFSET_NARROW_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm16;
    logic        out_ovf;
    logic        out_misalign;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;

    branch_offset_narrow dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_target    (in_target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm16    (out_imm16),
        .out_ovf      (out_ovf),
        .out_misalign (out_misalign),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected counter after one consumed result carrying the given flags.
    task automatic bump_err(input bit flagged);
        if (ERRCNT_EN && flagged && exp_err < 255) exp_err++;
    endtask

    // Sends one request with out_ready high and captures the result and its latency.
    task automatic run_single(input logic [31:0] pc, input logic [31:0] tgt,
                              output logic [15:0] imm, output logic ovf, output logic mis,
                              output int lat, output logic [7:0] err_before,
                              output logic [7:0] err_after);
        int waited = 0;
        out_ready = 1'b1;
        in_pc     = pc;
        in_target = tgt;
        in_valid  = 1'b1;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat >= 20 || waited >= 20) begin
            errors++;
            $display("[TB] FAIL run_single_timeout: lat=%0d wait=%0d required result within bound", lat, waited);
        end
        imm        = out_imm16;
        ovf        = out_ovf;
        mis        = out_misalign;
        err_before = err_cnt;
        step();
        err_after  = err_cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_pc = '0;
        in_target = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_imm16 !== 16'h0000 || out_ovf !== 1'b0 || out_misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b imm=%h ovf=%b mis=%b, required 0/0000/0/0",
                     out_valid, out_imm16, out_ovf, out_misalign);
        end
        checks++;
        if (err_cnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_err_cnt: got %h required 00", err_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
        end
        step();
    endtask

    task automatic test_branch(input string name, input logic [31:0] pc, input logic [31:0] tgt,
                               input logic [15:0] e_imm, input logic e_ovf, input logic e_mis);
        logic [15:0] imm;
        logic ovf, mis;
        int lat;
        logic [7:0] eb, ea;
        int prev_err;
        run_single(pc, tgt, imm, ovf, mis, lat, eb, ea);
        checks++;
        if (imm !== e_imm || ovf !== e_ovf || mis !== e_mis) begin
            errors++;
            $display("[TB] FAIL %s_result: got imm=%h ovf=%b mis=%b required imm=%h ovf=%b mis=%b",
                     name, imm, ovf, mis, e_imm, e_ovf, e_mis);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d required 2", name, lat);
        end
        checks++;
        if (eb !== 8'(exp_err)) begin
            errors++;
            $display("[TB] FAIL %s_err_before_handshake: got %h required %h", name, eb, 8'(exp_err));
        end
        prev_err = exp_err;
        bump_err(e_ovf | e_mis);
        checks++;
        if (ea !== 8'(exp_err)) begin
            errors++;
            $display("[TB] FAIL %s_err_after_handshake: got %h required %h (was %h)",
                     name, ea, 8'(exp_err), 8'(prev_err));
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_imm [3];
        exp_imm[0] = 16'h0003;
        exp_imm[1] = 16'h0007;
        exp_imm[2] = 16'h000B;
        out_ready = 1'b0;
        in_pc = 32'h0;
        in_target = 32'h10;
        in_valid = 1'b1;
        step();
        in_target = 32'h20;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_second_accept: in_ready=%b required 1", in_ready);
        end
        step();
        in_target = 32'h30;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm16 !== exp_imm[0]) begin
                errors++;
                $display("[TB] FAIL bp_stall_cycle%0d: ready=%b v=%b imm=%h required 0/1/%h",
                         i, in_ready, out_valid, out_imm16, exp_imm[0]);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_imm16 !== exp_imm[i]) begin
                errors++;
                $display("[TB] FAIL bp_drain%0d: v=%b imm=%h required 1/%h", i, out_valid, out_imm16, exp_imm[i]);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_empty: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        out_ready = 1'b0;
        in_pc = 32'h0;
        in_target = 32'h0000_000A;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_err = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_clear: v=%b err=%h required 0/00", out_valid, err_cnt);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) stale++;
            step();
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("[TB] FAIL midreset_stale: got %0d stale results required 0", stale);
        end
    endtask

    task automatic test_saturation();
        int results = 0;
        int stalls = 0;
        out_ready = 1'b1;
        in_pc = 32'h0;
        in_target = 32'h0000_000A;
        for (int i = 0; i < 306; i++) begin
            in_valid = (i < 300);
            #1;
            if (out_valid) results++;
            if (in_valid && !in_ready) stalls++;
            step();
        end
        for (int i = 0; i < 300; i++) bump_err(1'b1);
        checks++;
        if (results != 300 || stalls != 0) begin
            errors++;
            $display("[TB] FAIL sat_throughput: results=%0d stalls=%0d required 300/0", results, stalls);
        end
        checks++;
        if (err_cnt !== 8'(exp_err) || (ERRCNT_EN && err_cnt !== 8'hFF)) begin
            errors++;
            $display("[TB] FAIL sat_err_cnt: got %h required %h", err_cnt, 8'(exp_err));
        end
    endtask

    initial begin
        test_reset();
        test_branch("forward",   32'h0040_0000, 32'h0040_0010, 16'h0003, 1'b0, 1'b0);
        test_branch("backward",  32'h0000_1000, 32'h0000_0FF0, 16'hFFFB, 1'b0, 1'b0);
        test_branch("max_pos",   32'h0,         32'h0002_0000, 16'h7FFF, 1'b0, 1'b0);
        test_branch("over_pos",  32'h0,         32'h0002_0004, 16'h8000, 1'b1, 1'b0);
        test_branch("min_neg",   32'h0,         32'hFFFE_0004, 16'h8000, 1'b0, 1'b0);
        test_branch("under_neg", 32'h0,         32'hFFFE_0000, 16'h7FFF, 1'b1, 1'b0);
        test_branch("misalign",  32'h0,         32'h0000_000A, 16'h0001, 1'b0, 1'b1);
        test_branch("both_flag", 32'h0,         32'h0002_0006, 16'h8000, 1'b1, 1'b1);
        test_backpressure();
        test_reset_midflight();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
